// File: rtl/divider_pkg.sv
// Shared constants, FSM state encoding and helpers for the signed
// restoring divider.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Magnitude of a two's complement value; the most negative value maps
    // onto itself, which still reads correctly as an unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Operand/result bundle between the control unit and the divider.
interface divider_if;
    import divider_pkg::*;

    logic                 DivCtrl;
    logic [DIV_WIDTH-1:0] RegA;
    logic [DIV_WIDTH-1:0] RegB;
    logic [DIV_WIDTH-1:0] HI;
    logic [DIV_WIDTH-1:0] LO;
    logic                 DivDone;
    logic                 DivZero;
    logic                 DivBusy;

    modport master (output DivCtrl, RegA, RegB,
                    input  HI, LO, DivDone, DivZero, DivBusy);
    modport slave  (input  DivCtrl, RegA, RegB,
                    output HI, LO, DivDone, DivZero, DivBusy);
endinterface

// File: rtl/divider_div_step.sv
// One unsigned restoring-division iteration on the remainder:quotient pair.
module div_step
    import divider_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic [DIV_WIDTH-1:0] quo_i,
    input  logic [DIV_WIDTH-1:0] dvs_i,
    output logic [DIV_WIDTH-1:0] rem_o,
    output logic [DIV_WIDTH-1:0] quo_o
);

    logic [DIV_WIDTH:0] shifted;
    logic [DIV_WIDTH:0] trial;

    // Remainder stays below the divisor (<= 2^31), so 33 bits hold the
    // shifted value and the trial result's top bit is its sign.
    always_comb begin
        shifted = {rem_i, quo_i[DIV_WIDTH-1]};
        trial   = shifted - {1'b0, dvs_i};
        if (!trial[DIV_WIDTH]) begin
            rem_o = trial[DIV_WIDTH-1:0];
            quo_o = {quo_i[DIV_WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[DIV_WIDTH-1:0];
            quo_o = {quo_i[DIV_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed divider with MIPS div semantics: 32 restoring steps
// on magnitudes, then a sign fix-up before HI/LO are written.
module divider
    import divider_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    divider_if.slave  bus
);

    div_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic [DIV_WIDTH-1:0] hi_q, hi_d;
    logic [DIV_WIDTH-1:0] lo_q, lo_d;
    logic                 zero_q, zero_d;

    logic [DIV_WIDTH-1:0] step_rem;
    logic [DIV_WIDTH-1:0] step_quo;

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.DivCtrl) begin
                    if (bus.RegB == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        quo_d   = abs_val(bus.RegA);
                        dvs_d   = abs_val(bus.RegB);
                        rem_d   = '0;
                        sa_d    = bus.RegA[DIV_WIDTH-1];
                        sb_d    = bus.RegB[DIV_WIDTH-1];
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = FIX;
            end
            FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                lo_d    = (sa_q ^ sb_q) ? -quo_q : quo_q;
                hi_d    = sa_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.DivDone = (state_q == DONE);
    assign bus.DivZero = zero_q;
    assign bus.DivBusy = (state_q != IDLE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table plus hand-written corner
// sequences, results checked through an expected-value queue.
module tb_divider;
    import divider_pkg::*;

    logic clock = 1'b0;
    logic reset;

    divider_if dif ();

    divider dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Result monitor: every DivDone pops one expected {HI,LO} pair.
    always @(negedge clock) begin : mon
        logic [63:0] e;
        if (dif.DivDone === 1'b1) begin
            done_cnt++;
            check("done_zero_excl", {31'b0, dif.DivZero}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("LO", dif.LO, e[31:0]);
                check("HI", dif.HI, e[63:32]);
            end
        end
    end

    // Waits for DivDone, expecting it on the exp_lat-th falling edge with
    // DivBusy high throughout, then DivBusy low on the following one.
    task automatic wait_done(input int exp_lat);
        int lat  = 0;
        int busy = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (dif.DivBusy === 1'b1) busy++;
            if (dif.DivDone === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("busy_cycles", busy, exp_lat);
        @(negedge clock);
        check("busy_after_done", {31'b0, dif.DivBusy}, 32'd0);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dif.DivCtrl = 1'b1;
        dif.RegA    = a;
        dif.RegB    = b;
        @(posedge clock);
        #1;
        dif.DivCtrl = 1'b0;
        // Operands change after the start edge; the result must not.
        dif.RegA    = $urandom;
        dif.RegB    = $urandom;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi);
        exp_q.push_back({hi, lo});
        start(a, b);
        wait_done(34);
    endtask

    initial begin
        int d0;
        vt[0]  = '{32'd100,       32'd7,          32'd14,         32'd2};
        vt[1]  = '{32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vt[2]  = '{32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vt[3]  = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0};
        vt[4]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
        vt[5]  = '{32'd0,         32'd5,          32'd0,          32'd0};
        vt[6]  = '{32'd5,         32'd1,          32'd5,          32'd0};
        vt[7]  = '{32'd1,         32'h80000000,   32'd0,          32'd1};
        vt[8]  = '{32'h80000000,  32'h80000000,   32'd1,          32'd0};
        vt[9]  = '{32'h7FFFFFFF,  32'h80000000,   32'd0,          32'h7FFFFFFF};
        vt[10] = '{32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,          32'd0};
        vt[11] = '{32'd12345678,  32'd1000,       32'd12345,      32'd678};

        dif.DivCtrl = 1'b0;
        dif.RegA    = '0;
        dif.RegB    = '0;
        reset       = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_HI",   dif.HI, 32'd0);
        check("rst_LO",   dif.LO, 32'd0);
        check("rst_busy", {31'b0, dif.DivBusy}, 32'd0);
        check("rst_done", {31'b0, dif.DivDone}, 32'd0);
        check("rst_zero", {31'b0, dif.DivZero}, 32'd0);

        // Reset wins over a start request on the same edge.
        dif.DivCtrl = 1'b1;
        dif.RegA    = 32'd100;
        dif.RegB    = 32'd7;
        reset       = 1'b1;
        @(posedge clock);
        #1;
        reset       = 1'b0;
        dif.DivCtrl = 1'b0;
        @(negedge clock);
        check("rst_prio_busy", {31'b0, dif.DivBusy}, 32'd0);

        foreach (vt[i]) run_div(vt[i].a, vt[i].b, vt[i].lo, vt[i].hi);

        // Divide by zero after 100/7: flag only, results retained.
        run_div(32'd100, 32'd7, 32'd14, 32'd2);
        d0 = done_cnt;
        start(32'd5, 32'd0);
        @(negedge clock);
        check("dz_zero", {31'b0, dif.DivZero}, 32'd1);
        check("dz_busy", {31'b0, dif.DivBusy}, 32'd0);
        check("dz_done", {31'b0, dif.DivDone}, 32'd0);
        @(negedge clock);
        check("dz_zero_pulse", {31'b0, dif.DivZero}, 32'd0);
        repeat (5) @(negedge clock);
        check("dz_HI_hold", dif.HI, 32'd2);
        check("dz_LO_hold", dif.LO, 32'd14);
        check("dz_no_done", done_cnt - d0, 32'd0);

        // Start request while busy must be ignored.
        exp_q.push_back({32'd2, 32'd14});
        start(32'd100, 32'd7);
        repeat (4) @(negedge clock);
        dif.DivCtrl = 1'b1;
        dif.RegA    = 32'd9;
        dif.RegB    = 32'd3;
        @(posedge clock);
        #1 dif.DivCtrl = 1'b0;
        wait_done(30);
        d0 = done_cnt;
        repeat (40) @(negedge clock);
        check("ovl_no_second_done", done_cnt - d0, 32'd0);

        // Reset mid-calculation aborts with no completion.
        exp_q.push_back({32'd2, 32'd14});
        start(32'd100, 32'd7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clock);
        check("abort_HI",   dif.HI, 32'd0);
        check("abort_LO",   dif.LO, 32'd0);
        check("abort_busy", {31'b0, dif.DivBusy}, 32'd0);
        repeat (40) @(negedge clock);
        check("abort_no_done", done_cnt - d0, 32'd0);
        run_div(32'd9, 32'd3, 32'd3, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
